// File: rtl/led_chaser_pkg.sv
// Shared types for the LED chaser: pattern mode encoding, bounce-direction
// constants and the divider width helper.
package led_chaser_pkg;

    typedef logic [1:0] mode_t;

    typedef enum mode_t {
        ROTATE = 2'b00,
        BOUNCE = 2'b01,
        FILL   = 2'b10,
        HOLD   = 2'b11
    } mode_e;

    localparam logic BOUNCE_UP   = 1'b0;
    localparam logic BOUNCE_DOWN = 1'b1;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/led_chaser_if.sv
// Control/status bundle between a pattern controller and the LED chaser.
// With LED_CHASER_PWM_EN defined the bundle also carries the 4-bit brightness.
interface led_chaser_if #(
    parameter int unsigned N_LEDS = 4
);
    logic [1:0]        mode;
    logic              dir;
    logic              pause;
    logic [N_LEDS-1:0] leds;
    logic              step;
    logic              pwr;
`ifdef LED_CHASER_PWM_EN
    logic [3:0]        bright;
`endif

    modport master (
        output mode,
        output dir,
        output pause,
`ifdef LED_CHASER_PWM_EN
        output bright,
`endif
        input  leds,
        input  step,
        input  pwr
    );

    modport slave (
        input  mode,
        input  dir,
        input  pause,
`ifdef LED_CHASER_PWM_EN
        input  bright,
`endif
        output leds,
        output step,
        output pwr
    );
endinterface

// File: rtl/led_tick_div.sv
// Step-rate divider: counts 0..DIV-1 while enabled and flags the last count.
module led_tick_div
    import led_chaser_pkg::*;
#(
    parameter int unsigned DIV = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned      CntW   = clog2(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            at_max;

    assign at_max = (cnt_q == CntMax);
    // A clear wins over a pending tick so a reseed never steps in the same cycle.
    assign tick   = en && at_max && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_max ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_chaser.sv
// LED pattern generator: rotate, bounce, fill or hold, advancing once per DIV clocks.
// Define LED_CHASER_PWM_EN to add 4-bit PWM brightness on the outputs.
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int unsigned N_LEDS = 4,
    parameter int unsigned DIV    = 12000000
) (
    input  logic         clk,
    input  logic         rst,
    led_chaser_if.slave  bus
);
    localparam logic [N_LEDS-1:0] LsbHot  = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] MsbHot  = LsbHot << (N_LEDS - 1);
    localparam logic [N_LEDS-1:0] AllOnes = {N_LEDS{1'b1}};

    mode_e             mode_in;
    mode_e             mode_q;
    logic              mode_chg;
    logic              div_en;
    logic              tick;
    logic [N_LEDS-1:0] pat_q;
    logic [N_LEDS-1:0] pat_d;
    logic [N_LEDS-1:0] seed;
    logic [N_LEDS-1:0] next_pat;
    logic              bdir_q;
    logic              bdir_d;
    logic              step_q;

    assign mode_in  = mode_e'(bus.mode);
    assign mode_chg = (mode_in != mode_q);
    assign div_en   = !bus.pause && (mode_q != HOLD);

    led_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (mode_chg),
        .tick (tick)
    );

    always_comb begin
        seed = pat_q;
        unique case (mode_in)
            ROTATE:  seed = bus.dir ? MsbHot : LsbHot;
            BOUNCE:  seed = LsbHot;
            FILL:    seed = '0;
            HOLD:    seed = pat_q;
            default: seed = pat_q;
        endcase
    end

    always_comb begin
        next_pat = pat_q;
        unique case (mode_q)
            ROTATE: begin
                next_pat = bus.dir ? {pat_q[0], pat_q[N_LEDS-1:1]}
                                   : {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
            end
            BOUNCE: begin
                next_pat = (bdir_q == BOUNCE_DOWN) ? (pat_q >> 1) : (pat_q << 1);
            end
            FILL: begin
                if (pat_q == AllOnes) begin
                    next_pat = '0;
                end else begin
                    next_pat = bus.dir ? {1'b1, pat_q[N_LEDS-1:1]}
                                       : {pat_q[N_LEDS-2:0], 1'b1};
                end
            end
            HOLD:    next_pat = pat_q;
            default: next_pat = pat_q;
        endcase
    end

    always_comb begin
        pat_d  = pat_q;
        bdir_d = bdir_q;
        if (mode_chg) begin
            pat_d  = seed;
            bdir_d = BOUNCE_UP;
        end else if (tick) begin
            pat_d = next_pat;
            // Turn around on the tick that lands on an end, so each end shows for one step.
            if (mode_q == BOUNCE) begin
                if (next_pat[N_LEDS-1]) begin
                    bdir_d = BOUNCE_DOWN;
                end else if (next_pat[0]) begin
                    bdir_d = BOUNCE_UP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= ROTATE;
            pat_q  <= LsbHot;
            bdir_q <= BOUNCE_UP;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_in;
            pat_q  <= pat_d;
            bdir_q <= bdir_d;
            step_q <= tick;
        end
    end

`ifdef LED_CHASER_PWM_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
        end
    end

    assign bus.leds = (pwm_q < bus.bright) ? pat_q : '0;
`else
    assign bus.leds = pat_q;
`endif

    assign bus.step = step_q;
    assign bus.pwr  = 1'b1;

endmodule

// File: tb/tb_led_chaser.sv
// Scoreboard bench for led_chaser (N_LEDS=4, DIV=4): expected step patterns and
// their cycle numbers are queued at stimulus time and popped on each step pulse.
`timescale 1ns/1ps
module tb_led_chaser;
    localparam int unsigned NL = 4;
    localparam int unsigned DV = 4;

    typedef struct {
        logic [NL-1:0] leds;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   last_step = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t mon_item;

    led_chaser_if #(.N_LEDS(NL)) bus ();

    led_chaser #(
        .N_LEDS (NL),
        .DIV    (DV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        int guard = 500;
        while (cyc < target && guard > 0) begin
            @(posedge clk);
            #1;
            guard--;
        end
    endtask

    task automatic push(input logic [NL-1:0] l, input int c);
        exp_t item;
        item.leds = l;
        item.cyc  = c;
        exp_q.push_back(item);
    endtask

    task automatic drain(input string tag);
        int budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Every step pulse must match the head of the scoreboard in both timing and pattern.
    always @(negedge clk) begin
        if (!rst && bus.step === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexp_step", 32'(bus.step), 32'd0);
            end else begin
                mon_item = exp_q.pop_front();
                check_eq("step_cyc", 32'(cyc), 32'(mon_item.cyc));
                check_eq("step_leds", 32'(bus.leds), 32'(mon_item.leds));
            end
            last_step = cyc;
        end
    end

    initial begin
        int c;
        logic [NL-1:0] bseq[7];
        logic [NL-1:0] fseq[6];
        bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        fseq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b1000};

        bus.mode  = 2'b00;
        bus.dir   = 1'b0;
        bus.pause = 1'b0;
`ifdef LED_CHASER_PWM_EN
        bus.bright = 4'd4;
        bus.mode   = 2'b11;
        cyc_wait(3);
        rst = 1'b0;
        cyc_wait(4);
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += int'(bus.leds[0]);
            cyc_wait(1);
        end
        check_eq("pwm_b4_on", 32'(c), 32'd8);
        check_eq("pwm_b4_off_bits", 32'(bus.leds[NL-1:1]), 32'd0);
        bus.bright = 4'd0;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += int'(bus.leds != '0);
            cyc_wait(1);
        end
        check_eq("pwm_b0_on", 32'(c), 32'd0);
`else
        cyc_wait(3);
        check_eq("rst_leds", 32'(bus.leds), 32'b0001);
        check_eq("rst_step", 32'(bus.step), 32'd0);
        check_eq("pwr", 32'(bus.pwr), 32'd1);

        // Rotate from reset: first step DIV cycles after release.
        c = cyc;
        rst = 1'b0;
        push(4'b0010, c + 4);
        push(4'b0100, c + 8);
        push(4'b1000, c + 12);
        push(4'b0001, c + 16);
        push(4'b0010, c + 20);
        drain("rotate_drain");

        // Bounce.
        c = cyc;
        bus.mode = 2'b01;
        for (int i = 0; i < 7; i++) push(bseq[i], c + 1 + 4 * (i + 1));
        cyc_wait(1);
        check_eq("bounce_seed", 32'(bus.leds), 32'b0001);
        check_eq("bounce_seed_step", 32'(bus.step), 32'd0);
        drain("bounce_drain");

        // Fill toward LSB from the MSB.
        c = cyc;
        bus.mode = 2'b10;
        bus.dir  = 1'b1;
        for (int i = 0; i < 6; i++) push(fseq[i], c + 1 + 4 * (i + 1));
        cyc_wait(1);
        check_eq("fill_seed", 32'(bus.leds), 32'b0000);
        drain("fill_drain");

        // Pause with the divider at 2.
        c = cyc;
        bus.mode = 2'b00;
        bus.dir  = 1'b0;
        push(4'b0010, c + 5);
        push(4'b0100, c + 19);
        push(4'b1000, c + 23);
        cyc_wait(1);
        check_eq("rot_seed", 32'(bus.leds), 32'b0001);
        wait_until(c + 7);
        bus.pause = 1'b1;
        cyc_wait(10);
        check_eq("pause_leds", 32'(bus.leds), 32'b0010);
        bus.pause = 1'b0;
        drain("pause_drain");

        // Hold at 0100, then back to rotate.
        c = last_step;
        push(4'b0001, c + 4);
        push(4'b0010, c + 8);
        push(4'b0100, c + 12);
        wait_until(c + 13);
        check_eq("pre_hold_leds", 32'(bus.leds), 32'b0100);
        bus.mode = 2'b11;
        for (int i = 0; i < 20; i++) begin
            cyc_wait(1);
            if (i == 0 || i == 19) check_eq("hold_leds", 32'(bus.leds), 32'b0100);
        end
        c = cyc;
        push(4'b0010, c + 5);
        bus.mode = 2'b00;
        cyc_wait(1);
        check_eq("hold_exit_seed", 32'(bus.leds), 32'b0001);
        drain("hold_drain");

        // Direction change takes effect on the next tick, no reseed.
        c = last_step;
        push(4'b0001, c + 4);
        push(4'b1000, c + 8);
        bus.dir = 1'b1;
        cyc_wait(1);
        check_eq("dir_noreseed", 32'(bus.leds), 32'b0010);
        drain("dir_drain");

        // Mode change while paused still reseeds; divider stays cleared.
        c = cyc;
        bus.mode  = 2'b10;
        bus.dir   = 1'b0;
        bus.pause = 1'b1;
        cyc_wait(1);
        check_eq("pause_reseed", 32'(bus.leds), 32'b0000);
        cyc_wait(4);
        check_eq("pause_hold", 32'(bus.leds), 32'b0000);
        push(4'b0001, c + 9);
        push(4'b0011, c + 13);
        bus.pause = 1'b0;
        drain("pause_mode_drain");

        // Reset overrides pause and mode.
        bus.pause = 1'b1;
        bus.mode  = 2'b01;
        rst = 1'b1;
        cyc_wait(3);
        check_eq("rst2_leds", 32'(bus.leds), 32'b0001);
        check_eq("rst2_step", 32'(bus.step), 32'd0);
        c = cyc;
        rst = 1'b0;
        bus.pause = 1'b0;
        bus.mode  = 2'b00;
        push(4'b0010, c + 4);
        drain("rst2_drain");
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
